// File: rtl/dual_issue_steer_pkg.sv
// Shared core definitions for the dual-issue decode steering slice:
// opcodes, the bubble instruction, steering state and opcode classifiers.
package dual_issue_steer_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    typedef enum logic {
        ST_PAIR   = 1'b0,
        ST_SECOND = 1'b1
    } steer_state_e;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic is_ctl_op(input logic [6:0] op);
        return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    function automatic logic reads_rs1(input logic [6:0] op);
        return (op == OP_REG) || (op == OP_IMM) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/pair_hazard_check.sv
// Classifies both slots of a fetched pair and decides whether the pair
// must be split into two single-instruction issue groups.
module pair_hazard_check
    import dual_issue_steer_pkg::*;
(
    input  logic       valid,
    input  logic [6:0] op0,
    input  logic [4:0] rd0,
    input  logic [6:0] op1,
    input  logic [4:0] rs1_1,
    input  logic [4:0] rs2_1,
    output logic       slot0_mem,
    output logic       slot1_mem,
    output logic       pair_both_mem,
    output logic       split_needed
);

    logic both_ctl;
    logic raw_dep;

    always_comb begin
        slot0_mem     = is_mem_op(op0);
        slot1_mem     = is_mem_op(op1);
        pair_both_mem = valid && slot0_mem && slot1_mem;
        both_ctl      = is_ctl_op(op0) && is_ctl_op(op1);
        // Raw rd bits are compared regardless of whether slot 0 writes rd.
        raw_dep       = (rd0 != 5'd0) &&
                        ((reads_rs1(op1) && (rs1_1 == rd0)) ||
                         (reads_rs2(op1) && (rs2_1 == rd0)));
        split_needed  = valid && (pair_both_mem || both_ctl || raw_dep);
    end

endmodule

// File: rtl/dual_issue_steer.sv
// Decode-stage steering of a fetched instruction pair onto the memory pipe
// (pipe 1) and the ALU/branch pipe (pipe 2), splitting conflicting pairs.
module dual_issue_steer #(
    parameter logic [31:0] NOP_INSTR = dual_issue_steer_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic [31:0] instr0_f_i,
    input  logic [31:0] instr1_f_i,
    input  logic [31:0] pc_f_i,
    input  logic        valid_f_i,
    input  logic        StallD,
    input  logic        FlushD,
    output logic [31:0] InstrD_1_o,
    output logic [31:0] InstrD_2_o,
    output logic [31:0] PCD_o,
    output logic        Order_Change_D_o,
    output logic        hold_f_o,
    output logic        both_mem_o
);

    import dual_issue_steer_pkg::*;

    steer_state_e state;
    logic [31:0]  lat_instr;
    logic [31:0]  lat_pc;
    logic         slot0_mem;
    logic         slot1_mem;
    logic         pair_both_mem;
    logic         split_needed;

    pair_hazard_check u_hazard (
        .valid         (valid_f_i),
        .op0           (instr0_f_i[6:0]),
        .rd0           (instr0_f_i[11:7]),
        .op1           (instr1_f_i[6:0]),
        .rs1_1         (instr1_f_i[19:15]),
        .rs2_1         (instr1_f_i[24:20]),
        .slot0_mem     (slot0_mem),
        .slot1_mem     (slot1_mem),
        .pair_both_mem (pair_both_mem),
        .split_needed  (split_needed)
    );

    // Independent of StallD so fetch never drops the pair while decode waits.
    assign hold_f_o = (state == ST_PAIR) && split_needed;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            InstrD_1_o       <= NOP_INSTR;
            InstrD_2_o       <= NOP_INSTR;
            PCD_o            <= '0;
            Order_Change_D_o <= 1'b0;
            both_mem_o       <= 1'b0;
            state            <= ST_PAIR;
            lat_instr        <= '0;
            lat_pc           <= '0;
        end else if (FlushD) begin
            InstrD_1_o       <= NOP_INSTR;
            InstrD_2_o       <= NOP_INSTR;
            PCD_o            <= '0;
            Order_Change_D_o <= 1'b0;
            both_mem_o       <= 1'b0;
            state            <= ST_PAIR;
            lat_instr        <= '0;
            lat_pc           <= '0;
        end else if (!StallD) begin
            case (state)
                ST_PAIR: begin
                    if (!valid_f_i) begin
                        InstrD_1_o       <= NOP_INSTR;
                        InstrD_2_o       <= NOP_INSTR;
                        PCD_o            <= '0;
                        Order_Change_D_o <= 1'b0;
                        both_mem_o       <= 1'b0;
                    end else if (split_needed) begin
                        InstrD_1_o       <= instr0_f_i;
                        InstrD_2_o       <= NOP_INSTR;
                        PCD_o            <= pc_f_i;
                        Order_Change_D_o <= 1'b0;
                        both_mem_o       <= pair_both_mem;
                        lat_instr        <= instr1_f_i;
                        lat_pc           <= pc_f_i + 32'd4;
                        state            <= ST_SECOND;
                    end else if (slot1_mem && !slot0_mem) begin
                        InstrD_1_o       <= instr1_f_i;
                        InstrD_2_o       <= instr0_f_i;
                        PCD_o            <= pc_f_i;
                        Order_Change_D_o <= 1'b1;
                        both_mem_o       <= 1'b0;
                    end else begin
                        InstrD_1_o       <= instr0_f_i;
                        InstrD_2_o       <= instr1_f_i;
                        PCD_o            <= pc_f_i;
                        Order_Change_D_o <= 1'b0;
                        both_mem_o       <= 1'b0;
                    end
                end
                ST_SECOND: begin
                    InstrD_1_o       <= lat_instr;
                    InstrD_2_o       <= NOP_INSTR;
                    PCD_o            <= lat_pc;
                    Order_Change_D_o <= 1'b0;
                    both_mem_o       <= 1'b0;
                    state            <= ST_PAIR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_issue_steer.sv
// Scoreboard bench for dual_issue_steer: directed pairs plus randomized
// pairs with stall/flush/reset, checked against an issue-group model.
module tb_dual_issue_steer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] i1;
        logic [31:0] i2;
        logic [31:0] pc;
        logic        oc;
        logic        bm;
    } grp_t;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic [31:0] instr0_f_i = '0;
    logic [31:0] instr1_f_i = '0;
    logic [31:0] pc_f_i = '0;
    logic        valid_f_i = 1'b0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic [31:0] InstrD_1_o;
    logic [31:0] InstrD_2_o;
    logic [31:0] PCD_o;
    logic        Order_Change_D_o;
    logic        hold_f_o;
    logic        both_mem_o;

    always #5 clk = ~clk;

    dual_issue_steer #(.NOP_INSTR(32'h0000_0013)) dut (
        .clk              (clk),
        .rstn_i           (rstn_i),
        .instr0_f_i       (instr0_f_i),
        .instr1_f_i       (instr1_f_i),
        .pc_f_i           (pc_f_i),
        .valid_f_i        (valid_f_i),
        .StallD           (StallD),
        .FlushD           (FlushD),
        .InstrD_1_o       (InstrD_1_o),
        .InstrD_2_o       (InstrD_2_o),
        .PCD_o            (PCD_o),
        .Order_Change_D_o (Order_Change_D_o),
        .hold_f_o         (hold_f_o),
        .both_mem_o       (both_mem_o)
    );

    int   checks = 0;
    int   errors = 0;
    grp_t exp_q[$];
    logic hold_q[$];
    grp_t pend[$];
    grp_t cur;
    logic fetch_keep = 1'b0;

    function automatic grp_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] pc, input logic oc, input logic bm);
        grp_t g;
        g.i1 = a; g.i2 = b; g.pc = pc; g.oc = oc; g.bm = bm;
        return g;
    endfunction

    function automatic grp_t nop_grp();
        return mk(NOP, NOP, 32'd0, 1'b0, 1'b0);
    endfunction

    function automatic grp_t dut_grp();
        return mk(InstrD_1_o, InstrD_2_o, PCD_o, Order_Change_D_o, both_mem_o);
    endfunction

    function automatic logic is_mem(input logic [31:0] x);
        return x[6:0] inside {7'b0000011, 7'b0100011};
    endfunction

    function automatic logic is_ctl(input logic [31:0] x);
        return x[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111};
    endfunction

    function automatic logic uses_rs1(input logic [31:0] x);
        return x[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
    endfunction

    function automatic logic uses_rs2(input logic [31:0] x);
        return x[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic logic must_split(input logic [31:0] a, input logic [31:0] b, input logic v);
        logic [4:0] rd;
        if (!v) return 1'b0;
        if (is_mem(a) && is_mem(b)) return 1'b1;
        if (is_ctl(a) && is_ctl(b)) return 1'b1;
        rd = a[11:7];
        if (rd == 5'd0) return 1'b0;
        return (uses_rs1(b) && b[19:15] == rd) || (uses_rs2(b) && b[24:20] == rd);
    endfunction

    task automatic check_grp(input string name, input grp_t got, input grp_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got i1=%h i2=%h pc=%h oc=%0b bm=%0b, expected i1=%h i2=%h pc=%h oc=%0b bm=%0b",
                     name, got.i1, got.i2, got.pc, got.oc, got.bm,
                     exp.i1, exp.i2, exp.pc, exp.oc, exp.bm);
        end
    endtask

    // One decode cycle: drive inputs and queue the expected hold and issue group.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                        input logic v, input logic st, input logic fl, input logic rst);
        logic h;
        @(negedge clk);
        if (rst) begin
            rstn_i = 1'b0;
            #1;
            check_grp("async_reset", dut_grp(), nop_grp());
            pend.delete();
            cur = nop_grp();
            #1;
            rstn_i = 1'b1;
        end
        instr0_f_i = a;
        instr1_f_i = b;
        pc_f_i     = pc;
        valid_f_i  = v;
        StallD     = st;
        FlushD     = fl;
        h = (pend.size() == 0) && must_split(a, b, v);
        hold_q.push_back(h);
        fetch_keep = h || st;
        if (fl) begin
            pend.delete();
            cur = nop_grp();
        end else if (!st) begin
            if (pend.size() != 0) cur = pend.pop_front();
            else if (!v) cur = nop_grp();
            else if (must_split(a, b, v)) begin
                cur = mk(a, NOP, pc, 1'b0, is_mem(a) && is_mem(b));
                pend.push_back(mk(b, NOP, pc + 32'd4, 1'b0, 1'b0));
            end else if (is_mem(b) && !is_mem(a)) cur = mk(b, a, pc, 1'b1, 1'b0);
            else cur = mk(a, b, pc, 1'b0, 1'b0);
        end
        exp_q.push_back(cur);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [8];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 7)]};
    endfunction

    // Monitor: hold_f_o late in the low phase, registered outputs just after the edge.
    initial begin
        logic h;
        grp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (hold_q.size() != 0) begin
                h = hold_q.pop_front();
                checks++;
                if (hold_f_o !== h) begin
                    errors++;
                    $display("FAIL hold_f_o: got %0b expected %0b at %0t", hold_f_o, h, $time);
                end
            end
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_grp("issue", dut_grp(), e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] ADD  = 32'h003100B3;
    localparam logic [31:0] SUB  = 32'h40628233;
    localparam logic [31:0] ADDI = 32'h00518093;
    localparam logic [31:0] LW7  = 32'h00012383;
    localparam logic [31:0] LW1  = 32'h00012083;
    localparam logic [31:0] SW3  = 32'h00312223;
    localparam logic [31:0] ADDI5 = 32'h00100293;
    localparam logic [31:0] ADD6  = 32'h00528333;
    localparam logic [31:0] ADDX0 = 32'h000000B3;

    initial begin
        logic [31:0] a, b, pc;
        cur = nop_grp();
        @(negedge clk);
        check_grp("reset_state", dut_grp(), nop_grp());
        checks++;
        if (hold_f_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got %0b expected 0", hold_f_o);
        end
        rstn_i = 1'b1;

        step(ADD, SUB, 32'h100, 1, 0, 0, 0);
        step(ADDI, LW7, 32'h200, 1, 0, 0, 0);
        step(LW1, SW3, 32'h300, 1, 0, 0, 0);
        step(LW1, SW3, 32'h300, 1, 0, 0, 0);
        step(ADDI5, ADD6, 32'h400, 1, 0, 0, 0);
        step(ADDI5, ADD6, 32'h400, 1, 0, 0, 0);
        step(NOP, ADDX0, 32'h500, 1, 0, 0, 0);
        step(ADD, SUB, 32'h580, 0, 0, 0, 0);
        step(LW1, SW3, 32'h600, 1, 0, 0, 0);
        step(LW1, SW3, 32'h600, 1, 0, 1, 0);
        step(LW1, SW3, 32'h700, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(LW1, SW3, 32'h700, 1, 1, 0, 0);
        step(LW1, SW3, 32'h700, 1, 0, 0, 0);
        step(LW1, SW3, 32'h800, 1, 0, 0, 0);
        step(ADD, SUB, 32'h900, 1, 0, 0, 1);
        step(ADD, SUB, 32'h900, 1, 0, 0, 0);
        step(LW1, SW3, 32'hFFFF_FFFC, 1, 0, 0, 0);
        step(LW1, SW3, 32'hFFFF_FFFC, 1, 0, 0, 0);

        a = '0; b = '0; pc = '0;
        for (int n = 0; n < 600; n++) begin
            if (!fetch_keep) begin
                a  = rand_instr();
                b  = rand_instr();
                pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom() >> 2, 2'b00};
            end
            step(a, b, pc, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
        end
        for (int n = 0; n < 3; n++) step(NOP, NOP, 32'd0, 0, 0, 0, 0);

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0 || hold_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending entries, expected 0/0", exp_q.size(), hold_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_issue_steer.md
DUAL_ISSUE_STEER -- requirements
Module: dual_issue_steer

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h00000013, the bubble instruction (addi x0,x0,0).
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rstn_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port instr0_f_i  in  32  older instruction of the fetched pair (PC = pc_f_i).
REQ-005 SHALL have port instr1_f_i  in  32  younger instruction of the fetched pair (PC = pc_f_i+4).
REQ-006 SHALL have port pc_f_i  in  32  pair base PC.
REQ-007 SHALL have port valid_f_i  in  1  pair valid.
REQ-008 SHALL have ports StallD and FlushD  in  1 each  decode hold and decode flush.
REQ-009 SHALL have port InstrD_1_o  out  32  pipe-1 instruction (memory-capable pipe).
REQ-010 SHALL have port InstrD_2_o  out  32  pipe-2 instruction (ALU/branch pipe, no memory).
REQ-011 SHALL have port PCD_o  out  32  pair base PC; pipe-2 PC = PCD_o+4 if Order_Change_D_o=0, else PCD_o.
REQ-012 SHALL have port Order_Change_D_o  out  1  set when pipe 2 holds the older instruction.
REQ-013 SHALL have port hold_f_o  out  1  combinational; fetch keeps the current pair.
REQ-014 SHALL have port both_mem_o  out  1  registered; the current pair split because both slots are memory ops.

Function
REQ-015 SHALL classify each slot by opcode[6:0]:
- mem: 0000011, 0100011
- ctl: 1100011, 1101111, 1100111
- rs1 used: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111
- rs2 used: 0110011, 0100011, 1100011
REQ-016 SHALL flag split_needed when valid_f_i and any of the following holds:
- both slots mem
- both slots ctl
- instr0 rd != 0 and equals a used rs field of instr1
REQ-017 SHALL use two states: PAIR and SECOND.
REQ-018 In PAIR without split_needed, on the next edge the block SHALL register the pair as follows:
- If instr1 is mem and instr0 is not: pipe1=instr1, pipe2=instr0, Order_Change=1.
- Otherwise: pipe1=instr0, pipe2=instr1, Order_Change=0.
- PCD_o=pc_f_i; state stays PAIR.
REQ-019 In PAIR with split_needed, the block SHALL:
- Drive hold_f_o=1 in that cycle.
- Register pipe1=instr0, pipe2=NOP_INSTR, PCD_o=pc_f_i, Order_Change=0.
- Latch instr1 and pc_f_i+4 internally; go to SECOND.
REQ-020 In SECOND, hold_f_o SHALL be 0, and the block SHALL then:
- Register pipe1=latched instr1, pipe2=NOP_INSTR, PCD_o=latched PC, Order_Change=0.
- Return to PAIR.
REQ-021 With valid_f_i=0 in PAIR, the block SHALL register both pipes as NOP_INSTR, PCD_o=0 and Order_Change=0.
REQ-022 StallD=1 SHALL freeze all output registers and state, and hold_f_o SHALL still reflect split_needed.
REQ-023 FlushD=1 SHALL take priority over StallD: it loads NOP/NOP, PCD_o=0, Order_Change=0, both_mem_o=0, state PAIR, and discards the latched instr1.
REQ-024 Decode latency SHALL be 1 cycle per issue group: a non-split pair issues in 1 cycle, a split pair in 2.
REQ-025 All PC arithmetic SHALL be 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0.

Reset
REQ-026 Reset SHALL asynchronously set:
- InstrD_1_o = InstrD_2_o = NOP_INSTR
- PCD_o = 0, Order_Change_D_o = 0, both_mem_o = 0
- state PAIR, latches cleared
REQ-027 Reset asserted while in SECOND SHALL abandon the latched instr1, and the first post-reset cycle SHALL be in PAIR.

Structure
REQ-028 Opcode constants, NOP_INSTR and the state enum SHALL live in the shared core package.
REQ-029 Slot classification and split_needed SHALL be one combinational sub-module, pair_hazard_check; the state machine and registers SHALL be in dual_issue_steer.

Verification
REQ-030 Pair add x1,x2,x3 / sub x4,x5,x6 at pc 0x100 -> next cycle pipe1=add, pipe2=sub, PCD=0x100, OC=0, hold_f_o never 1.
REQ-031 Pair addi x1 / lw x7,0(x2) at pc 0x200 -> pipe1=lw, pipe2=addi, OC=1, pipe-2 PC 0x200.
REQ-032 Pair lw x1,0(x2) / sw x3,4(x2) -> hold_f_o=1 for one cycle; issues lw/NOP (PCD 0x300), then sw/NOP (PCD 0x304), both_mem_o=1 on the first group.
REQ-033 Pair addi x5,x0,1 / add x6,x5,x5 -> split into two groups; rd=x0 in slot 0 with rs=x0 in slot 1 -> no split.
REQ-034 FlushD in SECOND -> NOP/NOP, PCD 0, state PAIR; StallD held 3 cycles mid-split -> outputs frozen, then resume.
REQ-035 rstn_i pulsed low mid-SECOND -> outputs NOP/NOP immediately, with no latched instr1 issued after release.
